// File: rtl/scomp_run_ctrl_if.sv
// Board/CPU-side bundle for the SCOMP run/step controller.
// master: board keys, switches and CPU state driving the controller.
// slave : the controller, returning the CPU advance strobe, status and LEDs.
interface scomp_run_ctrl_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 16,
  parameter int LED_W  = 8
) ();
  logic              step_key;
  logic              step_mode;
  logic [1:0]        rate_sel;
  logic              bp_en;
  logic [PC_W-1:0]   bp_addr;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] ir;
  logic [1:0]        disp_sel;
  logic              cpu_en;
  logic              halted;
  logic              bp_hit;
  logic [15:0]       step_cnt;
  logic [LED_W-1:0]  led;

  modport master (
    output step_key, step_mode, rate_sel, bp_en, bp_addr, pc, reg_a, ir, disp_sel,
    input  cpu_en, halted, bp_hit, step_cnt, led
  );

  modport slave (
    input  step_key, step_mode, rate_sel, bp_en, bp_addr, pc, reg_a, ir, disp_sel,
    output cpu_en, halted, bp_hit, step_cnt, led
  );
endinterface

// File: rtl/scomp_run_ctrl.sv
// Run/step controller for the SCOMP CPU on the BeMicro board.
// Generates a single-clock CPU enable at a selectable rate, a debounced
// single-step key, and a registered active-low LED display mux.
// Optional breakpoint logic is built when SCOMP_CTRL_BP_EN is defined;
// without it bp_en/bp_addr are ignored and bp_hit is tied low.
module scomp_run_ctrl #(
  parameter int TICK_DIV = 500000,
  parameter int DB_TICKS = 2,
  parameter int PC_W     = 8,
  parameter int DATA_W   = 16,
  parameter int LED_W    = 8
) (
  input logic               clk,
  input logic               reset,
  scomp_run_ctrl_if.slave   bus
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W  = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  logic [PRE_W-1:0] r_preCnt;
  logic [3:0]       r_dec10;
  logic [3:0]       r_dec100;
  logic             w_baseTick;
  logic             w_tick10;
  logic             w_tick100;
  logic             w_rateTick;

  logic [1:0]       r_keySync;
  logic [DB_W-1:0]  r_dbCnt;
  logic             r_dbLevel;
  logic             r_dbLevelDly;
  logic             w_keyPulse;

  state_t           r_state;
  state_t           w_stateNext;
  logic             w_cpuEnNext;
  logic             w_bpMatch;
  logic             r_cpuEn;
  logic             r_halted;
  logic [15:0]      r_stepCnt;

  logic [LED_W-1:0] w_dispVal;
  logic [LED_W-1:0] r_led;
  logic             w_unusedBits;

  assign w_baseTick = (r_preCnt == PRE_W'(TICK_DIV - 1));
  assign w_tick10   = w_baseTick && (r_dec10 == 4'd9);
  assign w_tick100  = w_tick10 && (r_dec100 == 4'd9);
  assign w_keyPulse = r_dbLevel & ~r_dbLevelDly;

  // Free-running prescaler and decade dividers; rate changes never reset them
  always_ff @(posedge clk) begin
    if (reset) begin
      r_preCnt <= '0;
      r_dec10  <= '0;
      r_dec100 <= '0;
    end else begin
      r_preCnt <= w_baseTick ? '0 : r_preCnt + 1'b1;
      if (w_baseTick) r_dec10 <= (r_dec10 == 4'd9) ? 4'd0 : r_dec10 + 4'd1;
      if (w_tick10)   r_dec100 <= (r_dec100 == 4'd9) ? 4'd0 : r_dec100 + 4'd1;
    end
  end

  // Pick the advance rate for free-run mode
  always_comb begin
    w_rateTick = 1'b1;
    case (bus.rate_sel)
      2'd0:    w_rateTick = 1'b1;
      2'd1:    w_rateTick = w_baseTick;
      2'd2:    w_rateTick = w_tick10;
      default: w_rateTick = w_tick100;
    endcase
  end

  // Synchronise the key, then accept a new level after DB_TICKS agreeing base-tick samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_keySync    <= '0;
      r_dbCnt      <= '0;
      r_dbLevel    <= 1'b0;
      r_dbLevelDly <= 1'b0;
    end else begin
      r_keySync    <= {r_keySync[0], bus.step_key};
      r_dbLevelDly <= r_dbLevel;
      if (w_baseTick) begin
        if (r_keySync[1] != r_dbLevel) begin
          if (r_dbCnt == DB_W'(DB_TICKS - 1)) begin
            r_dbLevel <= r_keySync[1];
            r_dbCnt   <= '0;
          end else begin
            r_dbCnt <= r_dbCnt + 1'b1;
          end
        end else begin
          r_dbCnt <= '0;
        end
      end
    end
  end

`ifdef SCOMP_CTRL_BP_EN
  logic r_skipBp;
  logic r_bpHit;

  assign w_bpMatch  = bus.bp_en && (bus.pc == bus.bp_addr) && !r_skipBp;
  assign bus.bp_hit = r_bpHit;

  // Sticky hit flag, and a one-shot skip so resuming from the breakpoint PC does not re-trigger
  always_ff @(posedge clk) begin
    if (reset) begin
      r_skipBp <= 1'b0;
      r_bpHit  <= 1'b0;
    end else begin
      if (r_state == ST_STEP) begin
        r_bpHit <= 1'b0;
        if (!bus.step_mode) r_skipBp <= 1'b1;
      end else if (r_state == ST_RUN) begin
        if (w_bpMatch) r_bpHit <= 1'b1;
        if (bus.pc != bus.bp_addr) r_skipBp <= 1'b0;
      end
    end
  end
`else
  logic w_unusedBp;

  assign w_bpMatch  = 1'b0;
  assign bus.bp_hit = 1'b0;
  assign w_unusedBp = ^{bus.bp_en, bus.bp_addr};
`endif

  // Next state and the CPU enable decision that lands one clk later
  always_comb begin
    w_stateNext = r_state;
    w_cpuEnNext = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.step_mode || w_bpMatch) w_stateNext = ST_HALT;
        else                            w_cpuEnNext = w_rateTick;
      end
      ST_HALT: begin
        if (w_keyPulse) w_stateNext = ST_STEP;
      end
      ST_STEP: begin
        w_cpuEnNext = 1'b1;
        w_stateNext = bus.step_mode ? ST_HALT : ST_RUN;
      end
      default: w_stateNext = ST_RUN;
    endcase
  end

  // State register with the registered strobe, halt flag and step counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_cpuEn   <= 1'b0;
      r_halted  <= 1'b0;
      r_stepCnt <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_cpuEn  <= w_cpuEnNext;
      r_halted <= (w_stateNext == ST_HALT);
      if (r_state == ST_STEP) r_stepCnt <= r_stepCnt + 16'd1;
    end
  end

  // Select what the LEDs show
  always_comb begin
    w_dispVal = '0;
    case (bus.disp_sel)
      2'd0:    w_dispVal = bus.reg_a[LED_W-1:0];
      2'd1:    w_dispVal = bus.reg_a[2*LED_W-1:LED_W];
      2'd2:    w_dispVal = LED_W'(bus.pc);
      default: w_dispVal = bus.ir[LED_W-1:0];
    endcase
  end

  // LEDs are active-low, so store the inverted selection
  always_ff @(posedge clk) begin
    if (reset) r_led <= '1;
    else       r_led <= ~w_dispVal;
  end

  assign w_unusedBits = ^{bus.reg_a, bus.ir, bus.pc};

  assign bus.cpu_en   = r_cpuEn;
  assign bus.halted   = r_halted;
  assign bus.step_cnt = r_stepCnt;
  assign bus.led      = r_led;

endmodule

// File: tb/tb_scomp_run_ctrl.sv
// Directed bench for scomp_run_ctrl with a small CPU stand-in whose pc
// advances on cpu_en. Expected values go into a scoreboard queue as each
// step is set up and are popped when the matching output is sampled.
// Breakpoint expectations follow whether SCOMP_CTRL_BP_EN is defined.
`timescale 1ns/1ps
module tb_scomp_run_ctrl;
  localparam int TICK_DIV = 4;
  localparam int DB_TICKS = 2;
  localparam int PC_W     = 8;
  localparam int DATA_W   = 16;
  localparam int LED_W    = 8;

  logic            clk       = 1'b0;
  logic            reset     = 1'b1;
  logic            pcLoadEn  = 1'b1;
  logic [PC_W-1:0] pcLoadVal = '0;
  logic [PC_W-1:0] cpuPc;
  int              enCount   = 0;
  int              checks    = 0;
  int              errors    = 0;
  int              base;
  string           sbTag[$];
  logic [31:0]     sbExp[$];
  logic [1:0]      selSeq[4];
  logic [7:0]      ledSeq[4];
  logic [7:0]      prevLed;

  scomp_run_ctrl_if #(.PC_W(PC_W), .DATA_W(DATA_W), .LED_W(LED_W)) bus ();

  scomp_run_ctrl #(
    .TICK_DIV(TICK_DIV), .DB_TICKS(DB_TICKS), .PC_W(PC_W), .DATA_W(DATA_W), .LED_W(LED_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.pc = cpuPc;

  // CPU stand-in: pc advances on each cpu_en, or is loaded by the bench
  always @(posedge clk) begin
    if (pcLoadEn)              cpuPc <= pcLoadVal;
    else if (bus.cpu_en === 1'b1) cpuPc <= cpuPc + 1'b1;
  end

  // Count every clk in which cpu_en is high
  always @(posedge clk) begin
    if (bus.cpu_en === 1'b1) enCount <= enCount + 1;
  end

  // Hard stop in case a bounded wait is somehow bypassed
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExpect(input string tag, input logic [31:0] value);
    sbTag.push_back(tag);
    sbExp.push_back(value);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    string       tag;
    logic [31:0] expected;
    checks++;
    if (sbExp.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", observed);
    end else begin
      tag      = sbTag.pop_front();
      expected = sbExp.pop_front();
      assert (observed === expected) else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
    end
  endtask

  task automatic applyStimulus(input logic key, input int nClk);
    bus.step_key = key;
    repeat (nClk) @(negedge clk);
  endtask

  task automatic waitHalted(input int budget);
    for (int i = 0; i < budget && bus.halted !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic waitCpuEn(input int budget);
    for (int i = 0; i < budget && bus.cpu_en !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic waitStepState(input int budget);
    for (int i = 0; i < budget && dut.r_state !== 2'd2; i++) @(negedge clk);
  endtask

  task automatic measureRate(input logic [1:0] sel, input int window, input int pulses, input string tag);
    bus.rate_sel = sel;
    repeat (2) @(negedge clk);
    base = enCount;
    pushExpect(tag, 32'(pulses));
    repeat (window) @(negedge clk);
    checkOutput(32'(enCount - base));
  endtask

  initial begin
    bus.step_key  = 1'b0;
    bus.step_mode = 1'b0;
    bus.rate_sel  = 2'd1;
    bus.bp_en     = 1'b0;
    bus.bp_addr   = 8'h05;
    bus.reg_a     = 16'h1234;
    bus.ir        = 16'hA55A;
    bus.disp_sel  = 2'd0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    pushExpect("rst_cpu_en", 0);       checkOutput(32'(bus.cpu_en));
    pushExpect("rst_halted", 0);       checkOutput(32'(bus.halted));
    pushExpect("rst_bp_hit", 0);       checkOutput(32'(bus.bp_hit));
    pushExpect("rst_step_cnt", 0);     checkOutput(32'(bus.step_cnt));
    pushExpect("rst_led", 32'hFF);     checkOutput(32'(bus.led));

    pcLoadEn = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] free run at base tick rate");
    measureRate(2'd1, 40, 10, "rate1_pulses");
    pushExpect("run_halted", 0);       checkOutput(32'(bus.halted));
    pushExpect("led_rega_lo", 32'hCB); checkOutput(32'(bus.led));

    $display("[TB] key press in RUN is ignored");
    applyStimulus(1'b1, 12);
    applyStimulus(1'b0, 16);
    pushExpect("run_key_step_cnt", 0); checkOutput(32'(bus.step_cnt));
    pushExpect("run_key_halted", 0);   checkOutput(32'(bus.halted));

    $display("[TB] other rates");
    measureRate(2'd0, 20, 20, "rate0_pulses");
    measureRate(2'd2, 400, 10, "rate2_pulses");
    measureRate(2'd3, 800, 2, "rate3_pulses");

    // Breakpoint run uses the base-tick rate: at rate 0 a pulse already in
    // flight when pc reaches bp_addr would carry the CPU one instruction past it
    bus.rate_sel = 2'd1;
    pcLoadVal    = 8'h00;
    pcLoadEn     = 1'b1;
    @(negedge clk);
    pcLoadEn  = 1'b0;
    bus.bp_en = 1'b1;

`ifdef SCOMP_CTRL_BP_EN
    $display("[TB] breakpoint stop");
    waitHalted(200);
    pushExpect("bp_halted", 1);        checkOutput(32'(bus.halted));
    pushExpect("bp_pc", 32'h05);       checkOutput(32'(bus.pc));
    pushExpect("bp_hit_set", 1);       checkOutput(32'(bus.bp_hit));
    base = enCount;
    repeat (20) @(negedge clk);
    pushExpect("bp_quiet", 0);         checkOutput(32'(enCount - base));

    $display("[TB] resume from breakpoint");
    bus.step_key = 1'b1;
    waitCpuEn(60);
    pushExpect("resume_pulse", 1);     checkOutput(32'(bus.cpu_en));
    pushExpect("resume_bp_hit", 0);    checkOutput(32'(bus.bp_hit));
    pushExpect("resume_halted", 0);    checkOutput(32'(bus.halted));
    pushExpect("resume_step_cnt", 1);  checkOutput(32'(bus.step_cnt));
    bus.step_key = 1'b0;
    @(negedge clk);
    pushExpect("resume_pc", 32'h06);   checkOutput(32'(bus.pc));
    base = enCount;
    waitHalted(1400);
    pushExpect("wrap_halted", 1);      checkOutput(32'(bus.halted));
    pushExpect("wrap_pc", 32'h05);     checkOutput(32'(bus.pc));
    pushExpect("wrap_pulses", 255);    checkOutput(32'(enCount - base));
    pushExpect("wrap_bp_hit", 1);      checkOutput(32'(bus.bp_hit));
`else
    $display("[TB] breakpoint compare absent");
    base = enCount;
    repeat (200) @(negedge clk);
    pushExpect("nobp_halted", 0);      checkOutput(32'(bus.halted));
    pushExpect("nobp_bp_hit", 0);      checkOutput(32'(bus.bp_hit));
    pushExpect("nobp_pulses", 50);     checkOutput(32'(enCount - base));
`endif

    $display("[TB] single step with bouncing key");
    bus.bp_en     = 1'b0;
    bus.step_mode = 1'b1;
    reset         = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    pushExpect("step_mode_halted", 1); checkOutput(32'(bus.halted));
    base = enCount;
    for (int i = 0; i < 10; i++) begin
      bus.step_key = ~bus.step_key;
      @(negedge clk);
    end
    applyStimulus(1'b1, 12);
    applyStimulus(1'b0, 20);
    pushExpect("bounce_pulses", 1);    checkOutput(32'(enCount - base));
    pushExpect("bounce_step_cnt", 1);  checkOutput(32'(bus.step_cnt));
    pushExpect("bounce_halted", 1);    checkOutput(32'(bus.halted));

    $display("[TB] reset during STEP");
    bus.step_key = 1'b1;
    waitStepState(60);
    pushExpect("reached_step", 2);     checkOutput(32'(dut.r_state));
    reset        = 1'b1;
    bus.step_key = 1'b0;
    base         = enCount;
    @(negedge clk);
    pushExpect("rstep_cpu_en", 0);     checkOutput(32'(bus.cpu_en));
    pushExpect("rstep_step_cnt", 0);   checkOutput(32'(bus.step_cnt));
    pushExpect("rstep_led", 32'hFF);   checkOutput(32'(bus.led));
    pushExpect("rstep_halted", 0);     checkOutput(32'(bus.halted));
    reset = 1'b0;
    repeat (10) @(negedge clk);
    pushExpect("rstep_no_pulse", 0);   checkOutput(32'(enCount - base));

    $display("[TB] display select");
    pcLoadVal = 8'h3C;
    pcLoadEn  = 1'b1;
    @(negedge clk);
    pcLoadEn  = 1'b0;
    @(negedge clk);
    selSeq[0] = 2'd2; ledSeq[0] = 8'hC3;
    selSeq[1] = 2'd1; ledSeq[1] = 8'hED;
    selSeq[2] = 2'd3; ledSeq[2] = 8'hA5;
    selSeq[3] = 2'd0; ledSeq[3] = 8'hCB;
    prevLed   = 8'hCB;
    for (int i = 0; i < 4; i++) begin
      bus.disp_sel = selSeq[i];
      pushExpect("led_hold", 32'(prevLed));
      #1;
      checkOutput(32'(bus.led));
      pushExpect("led_sel", 32'(ledSeq[i]));
      @(negedge clk);
      checkOutput(32'(bus.led));
      prevLed = ledSeq[i];
    end
    pushExpect("disp_bp_hit", 0);      checkOutput(32'(bus.bp_hit));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
